// File: rtl/madd_pkg.sv
// Shared types, widths and the exact reference function for the approximate
// multiply-add sweep controller.
package madd_pkg;

    localparam int N_IN       = 6;
    localparam int N_OUT      = 4;
    localparam int ERR_W      = 4;
    localparam int SUM_W      = 10;
    localparam int CNT_W      = 7;
    localparam int ET_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // a = vec[1:0], b = vec[3:2], c = vec[5:4]; result is at most 3*3+3 = 12.
    function automatic logic [N_OUT-1:0] madd_exact(input logic [N_IN-1:0] vec);
        logic [N_OUT-1:0] a;
        logic [N_OUT-1:0] b;
        logic [N_OUT-1:0] c;
        a = {2'b00, vec[1:0]};
        b = {2'b00, vec[3:2]};
        c = {2'b00, vec[5:4]};
        return a * b + c;
    endfunction

endpackage

// File: rtl/madd_err_acc.sv
// Stage 2 of the sweep pipeline: absolute error, threshold compare and the
// max / sum / violation-count accumulators.
module madd_err_acc
    import madd_pkg::*;
#(
    parameter int ET = ET_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [N_OUT-1:0] exact,
    input  logic [N_OUT-1:0] approx,
    output logic [ERR_W-1:0] max_err,
    output logic [SUM_W-1:0] err_sum,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam logic [ERR_W-1:0] ET_L = ERR_W'(ET);

    logic [ERR_W-1:0] max_err_q, max_err_d;
    logic [SUM_W-1:0] err_sum_q, err_sum_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

    logic [ERR_W:0]   diff;
    logic [ERR_W:0]   abs_diff;
    logic [ERR_W-1:0] err;
    logic [SUM_W:0]   sum_ext;
    logic [CNT_W:0]   cnt_ext;

    always_comb begin
        diff     = {1'b0, exact} - {1'b0, approx};
        abs_diff = diff[ERR_W] ? (~diff + 1'b1) : diff;
        err      = abs_diff[ERR_W-1:0];
        sum_ext  = {1'b0, err_sum_q} + {{(SUM_W-ERR_W+1){1'b0}}, err};
        cnt_ext  = {1'b0, viol_cnt_q} + {{CNT_W{1'b0}}, (err > ET_L)};

        max_err_d  = max_err_q;
        err_sum_d  = err_sum_q;
        viol_cnt_d = viol_cnt_q;
        if (clear) begin
            max_err_d  = '0;
            err_sum_d  = '0;
            viol_cnt_d = '0;
        end else if (valid) begin
            if (err > max_err_q) max_err_d = err;
            // Saturating adds; the 64-vector sweep cannot reach the ceiling.
            err_sum_d  = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            viol_cnt_d = cnt_ext[CNT_W] ? {CNT_W{1'b1}} : cnt_ext[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_err_q  <= '0;
            err_sum_q  <= '0;
            viol_cnt_q <= '0;
        end else begin
            max_err_q  <= max_err_d;
            err_sum_q  <= err_sum_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign max_err  = max_err_q;
    assign err_sum  = err_sum_q;
    assign viol_cnt = viol_cnt_q;

endmodule

// File: rtl/madd_sweep_ctrl.sv
// Exhaustive 64-vector sweep of one madd netlist: FSM, vector counter and
// stage-1 capture; stage 2 lives in madd_err_acc.
module madd_sweep_ctrl
    import madd_pkg::*;
#(
    parameter int ET    = ET_DEFAULT,
    parameter int N_IN  = 6,
    parameter int N_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] max_err,
    output logic [SUM_W-1:0] err_sum,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             pass,
    output logic [1:0]       dbg_state
);

    localparam logic [ERR_W-1:0] ET_L = ERR_W'(ET);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             s1_valid_q, s1_valid_d;
    logic [N_OUT-1:0] s1_exact_q, s1_exact_d;
    logic [N_OUT-1:0] s1_approx_q, s1_approx_d;
    logic             pass_q, pass_d;
    logic             start_ok;
    logic             pass_now;

    // Control handshake: start is a one-cycle request honoured only in IDLE or
    // DONE; abort cancels SWEEP/DRAIN and always beats a simultaneous start.
    assign start_ok = start && !abort && (state_q == IDLE || state_q == DONE);
    assign pass_now = (max_err <= ET_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            s1_valid_q  <= s1_valid_d;
            s1_exact_q  <= s1_exact_d;
            s1_approx_q <= s1_approx_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_ok) state_d = SWEEP;
            SWEEP: begin
                if (abort)              state_d = IDLE;
                else if (&vec_q)        state_d = DRAIN;
            end
            DRAIN: state_d = abort ? IDLE : DONE;
            DONE:  state_d = start_ok ? SWEEP : IDLE;
            default: state_d = IDLE;
        endcase

        // The counter doubles as the registered netlist drive, so it rests at 0.
        vec_d       = (state_q == SWEEP && state_d == SWEEP) ? vec_q + 1'b1 : '0;
        s1_valid_d  = (state_q == SWEEP) && !abort;
        s1_exact_d  = madd_exact(vec_q);
        s1_approx_d = dut_out;
        pass_d      = (state_q == DONE) ? pass_now : pass_q;
    end

    always_comb begin
        dut_in    = vec_q;
        busy      = (state_q == SWEEP) || (state_q == DRAIN);
        done      = (state_q == DONE);
        pass      = done ? pass_now : pass_q;
        dbg_state = state_q;
    end

    madd_err_acc #(.ET(ET)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .valid    (s1_valid_q),
        .exact    (s1_exact_q),
        .approx   (s1_approx_q),
        .max_err  (max_err),
        .err_sum  (err_sum),
        .viol_cnt (viol_cnt)
    );

endmodule
